lifo_stream_ctrl: RTL

- Sequencer that sits directly upstream of the 5-bit up/down counter (counter_5bit) and drives its cntU, cntD and rst5 inputs.
- Consumes the counter's result and down_done to use it as a stack pointer over an internal register-file buffer.
- Accepts an input stream of up to DEPTH words, then replays them in reverse (LIFO) order on an output stream.
- Both streams use valid/ready handshakes; the block is the control front end for the CA3 reverse-order datapath.

---
 rtl/lifo_stream_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lifo_stream_ctrl.sv
// lifo_stream_ctrl: control front end of the reverse-order datapath.
// Collects a frame of up to DEPTH words into a small register file and
// replays it last-in first-out. An external 5-bit up/down counter acts as
// the stack pointer; this block drives its cntU/cntD/rst5 requests and reads
// back cnt_result/down_done one cycle later.
// Optional feature: define LIFO_FLUSH_EN to add a 'flush' input that abandons
// the current frame from FILL or DRAIN.
module lifo_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 31
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  input  logic [4:0]       cnt_result,
  input  logic             down_done,
  output logic             cntU,
  output logic             cntD,
  output logic             rst5,
  output logic             busy
);

  localparam logic [4:0] DEPTH5      = 5'(DEPTH);
  localparam logic [4:0] DEPTH5_LAST = 5'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [4:0]       rd_addr;
  logic             flush_hit;

`ifdef LIFO_FLUSH_EN
  assign flush_hit = flush && (state != IDLE);
`else
  assign flush_hit = 1'b0;
`endif

  // The top of stack sits one below the counter value; guard the read so an
  // empty stack (counter at zero) never indexes outside the buffer.
  assign rd_addr  = cnt_result - 5'd1;
  assign out_data = (rd_addr < DEPTH5) ? mem[rd_addr] : '0;

  // Handshake decode, counter requests and next-state selection.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    cntU       = 1'b0;
    cntD       = 1'b0;
    rst5       = 1'b0;
    busy       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cnt_result;
    next_state = state;
    if (!rst) begin
      rst5       = 1'b1;
      next_state = IDLE;
    end else if (flush_hit) begin
      rst5       = 1'b1;
      busy       = 1'b1;
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr_en      = 1'b1;
            wr_addr    = 5'd0;
            cntU       = 1'b1;
            next_state = (in_last || (DEPTH == 1)) ? DRAIN : FILL;
          end else begin
            rst5 = 1'b1;
          end
        end
        FILL: begin
          busy     = 1'b1;
          in_ready = (cnt_result != DEPTH5);
          if (in_valid && in_ready) begin
            wr_en = 1'b1;
            cntU  = 1'b1;
            if (in_last || (cnt_result == DEPTH5_LAST)) begin
              next_state = DRAIN;
            end
          end
        end
        DRAIN: begin
          busy      = 1'b1;
          out_valid = ~down_done;
          out_last  = (cnt_result == 5'd1);
          if (out_valid && out_ready) begin
            cntD = 1'b1;
          end
          if (down_done) begin
            next_state = IDLE;
          end
        end
        default: begin
          rst5       = 1'b1;
          next_state = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Buffer write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH5)) begin
      mem[wr_addr] <= in_data;
    end
  end

endmodule
